// File: rtl/eprisc_intctl_pkg.sv
// Shared constants for the epRISC interrupt controller: register map, FSM encoding,
// ID word and the VECTOR status bit positions.
package eprisc_intctl_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_ACK     = 3'd5;
  localparam logic [2:0] ADDR_NMICTL  = 3'd6;
  localparam logic [2:0] ADDR_ID      = 3'd7;

  localparam logic [31:0] ID_VALUE = 32'h4943_0001;

  localparam int VEC_VALID_BIT = 31;
  localparam int VEC_INSVC_BIT = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  // Lowest set bit wins; scanning downwards leaves the smallest index last.
  function automatic logic [3:0] lowest_index(input logic [15:0] req);
    lowest_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) lowest_index = 4'(i);
    end
  endfunction

endpackage

// File: rtl/eprisc_intctl_sync.sv
// Two-flop synchroniser for asynchronous request lines, with a one-cycle pulse
// on each rising edge of the synchronised level.
module eprisc_intctl_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] level_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q, sync_q, prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/eprisc_intctl.sv
// Memory-mapped interrupt controller: latches up to 16 sources, prioritises the
// lowest active index, and hands out claims/acks over the shared epRISC bus.
module eprisc_intctl
  import eprisc_intctl_pkg::*;
#(
  parameter int                 NUM_SRC    = 8,
  parameter logic [NUM_SRC-1:0] EDGE_RESET = '1
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [2:0]         iAddr,
  inout  wire  [31:0]        bData,
  input  logic               iWrite,
  input  logic               iEnable,
  input  logic [NUM_SRC-1:0] iIrq,
  input  logic               iNmi,
  output logic               oInt,
  output logic               oNMInt
);

  logic [NUM_SRC:0]   lvl, rise;
  logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d, edge_q, edge_d, pm;
  logic [15:0]        pm16;
  logic [3:0]         winner, cur_q, cur_d;
  logic [31:0]        rdata_q, rdata_d, vec_data;
  logic               nmi_q, nmi_d, oint_q, onmi_q;
  logic               rd_en, wr_en, claim, ack_hit, clr;
  state_e             state_q, state_d;
  logic               unused_bits;

  eprisc_intctl_sync #(.W(NUM_SRC + 1)) u_sync (
    .clk    (iClk),
    .rst_n  (iRst),
    .d_i    ({iNmi, iIrq}),
    .level_o(lvl),
    .rise_o (rise)
  );

  assign rd_en = iEnable & ~iWrite;
  assign wr_en = iEnable & iWrite;
  assign unused_bits = ^{lvl[NUM_SRC], bData[31:NUM_SRC]};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pm   = pending_q & mask_q;
    pm16 = '0;
    pm16[NUM_SRC-1:0] = pm;
    winner  = lowest_index(pm16);
    claim   = rd_en && (iAddr == ADDR_VECTOR) && (state_q == ST_REQ) && (|pm);
    ack_hit = wr_en && (iAddr == ADDR_ACK) && (state_q == ST_SVC) && (bData[3:0] == cur_q);

    vec_data = '0;
    if (state_q == ST_REQ && (|pm)) begin
      vec_data[VEC_VALID_BIT] = 1'b1;
      vec_data[3:0]           = winner;
    end else if (state_q == ST_SVC) begin
      vec_data[VEC_VALID_BIT] = 1'b1;
      vec_data[VEC_INSVC_BIT] = 1'b1;
      vec_data[3:0]           = cur_q;
    end
  end

  // Edge sources: a fresh edge beats any clear landing on the same cycle.
  always_comb begin
    pending_d = pending_q;
    clr       = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr = (wr_en && (iAddr == ADDR_PENDING) && bData[i]) || (claim && (winner == 4'(i)));
      pending_d[i] = edge_q[i] ? (rise[i] | (pending_q[i] & ~clr)) : lvl[i];
    end
    nmi_d = rise[NUM_SRC] | (nmi_q & ~(wr_en && (iAddr == ADDR_NMICTL) && bData[0]));
  end

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en && iAddr == ADDR_MASK) mask_d = bData[NUM_SRC-1:0];
    if (wr_en && iAddr == ADDR_EDGE) edge_d = bData[NUM_SRC-1:0];

    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (iAddr)
        ADDR_STATUS:  rdata_d = 32'(pm);
        ADDR_PENDING: rdata_d = 32'(pending_q);
        ADDR_MASK:    rdata_d = 32'(mask_q);
        ADDR_EDGE:    rdata_d = 32'(edge_q);
        ADDR_VECTOR:  rdata_d = vec_data;
        ADDR_NMICTL:  rdata_d = {31'd0, nmi_q};
        ADDR_ID:      rdata_d = ID_VALUE;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    unique case (state_q)
      ST_IDLE: if (|pm) state_d = ST_REQ;
      ST_REQ: begin
        if (claim) begin
          state_d = ST_SVC;
          cur_d   = winner;
        end else if (!(|pm)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SVC:  if (ack_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      edge_q    <= EDGE_RESET;
      cur_q     <= '0;
      nmi_q     <= 1'b0;
      rdata_q   <= '0;
      oint_q    <= 1'b0;
      onmi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      cur_q     <= cur_d;
      nmi_q     <= nmi_d;
      rdata_q   <= rdata_d;
      oint_q    <= (state_d == ST_REQ);
      onmi_q    <= nmi_q;
    end
  end

  assign oInt   = oint_q;
  assign oNMInt = onmi_q;
  assign bData  = (iEnable && !iWrite && iRst) ? rdata_q : 32'bz;

endmodule

// File: tb/tb_eprisc_intctl.sv
// Directed bench for eprisc_intctl: bus reads/writes, claim/ack flow, priority,
// level sources, ignored accesses, NMI and asynchronous reset.
module tb_eprisc_intctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  addr = '0;
  logic        wr = 1'b0, en = 1'b0, drv = 1'b0;
  logic [31:0] wdata = '0;
  logic [7:0]  irq = '0;
  logic        nmi = 1'b0;
  logic        oint, onmi;
  wire  [31:0] bdata;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] d;

  assign bdata = drv ? wdata : 32'bz;

  always #5 clk = ~clk;

  eprisc_intctl dut (
    .iClk   (clk),
    .iRst   (rst_n),
    .iAddr  (addr),
    .bData  (bdata),
    .iWrite (wr),
    .iEnable(en),
    .iIrq   (irq),
    .iNmi   (nmi),
    .oInt   (oint),
    .oNMInt (onmi)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk); addr = a; wr = 1'b1; en = 1'b1; drv = 1'b1; wdata = v;
    @(posedge clk);
    @(negedge clk); en = 1'b0; wr = 1'b0; drv = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk); addr = a; wr = 1'b0; en = 1'b1;
    @(posedge clk);
    @(negedge clk); v = bdata; en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL reset_oint: got %b want 0", oint); end
    n_checks++; if (onmi !== 1'b0) begin n_fail++; $display("FAIL reset_onmi: got %b want 0", onmi); end
    rst_n = 1'b1;
    bus_read(3'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 00000000", d); end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'hFF) begin n_fail++; $display("FAIL reset_edge: got %h want 000000ff", d); end
    bus_read(3'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 00000000", d); end
    bus_read(3'd7, d);
    n_checks++; if (d !== 32'h49430001) begin n_fail++; $display("FAIL reset_id: got %h want 49430001", d); end
  endtask

  task automatic test_edge;
    bus_write(3'd2, 32'h04);
    irq[2] = 1'b1;
    @(negedge clk); irq[2] = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL edge_oint_early: got %b want 0", oint); end
    @(negedge clk);
    n_checks++; if (oint !== 1'b1) begin n_fail++; $display("FAIL edge_oint_rise: got %b want 1", oint); end
    bus_read(3'd0, d);
    n_checks++; if (d !== 32'h04) begin n_fail++; $display("FAIL edge_status: got %h want 00000004", d); end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h80000002) begin n_fail++; $display("FAIL edge_vector: got %h want 80000002", d); end
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL edge_oint_claim: got %b want 0", oint); end
    bus_write(3'd5, 32'd2);
    bus_read(3'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_pending_after_ack: got %h want 00000000", d); end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_idle_after_ack: got %h want 00000000", d); end
  endtask

  task automatic test_priority;
    bus_write(3'd2, 32'hFF);
    irq[5] = 1'b1; irq[1] = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (oint !== 1'b1) begin n_fail++; $display("FAIL prio_oint: got %b want 1", oint); end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h80000001) begin n_fail++; $display("FAIL prio_vector_first: got %h want 80000001", d); end
    bus_write(3'd5, 32'd1);
    repeat (2) @(negedge clk);
    n_checks++; if (oint !== 1'b1) begin n_fail++; $display("FAIL prio_rerequest: got %b want 1", oint); end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h80000005) begin n_fail++; $display("FAIL prio_vector_second: got %h want 80000005", d); end
    bus_write(3'd5, 32'd5);
    irq[5] = 1'b0; irq[1] = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL prio_done: got %b want 0", oint); end
  endtask

  task automatic test_level;
    bus_write(3'd3, 32'h00);
    bus_write(3'd2, 32'h01);
    irq[0] = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (oint !== 1'b1) begin n_fail++; $display("FAIL level_oint: got %b want 1", oint); end
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h80000000) begin n_fail++; $display("FAIL level_vector: got %h want 80000000", d); end
    bus_write(3'd5, 32'd0);
    repeat (2) @(negedge clk);
    n_checks++; if (oint !== 1'b1) begin n_fail++; $display("FAIL level_reassert: got %b want 1", oint); end
    bus_write(3'd1, 32'h01);
    bus_read(3'd1, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL level_w1c_ignored: got %h want 00000001", d); end
    irq[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL level_drop: got %b want 0", oint); end
    repeat (3) @(negedge clk);
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL level_stays_low: got %b want 0", oint); end
    bus_write(3'd3, 32'hFF);
  endtask

  task automatic test_ignored;
    bus_write(3'd2, 32'hFF);
    irq[3] = 1'b1;
    @(negedge clk); irq[3] = 1'b0;
    repeat (4) @(negedge clk);
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h80000003) begin n_fail++; $display("FAIL ign_claim: got %h want 80000003", d); end
    bus_write(3'd5, 32'd4);
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'hC0000003) begin n_fail++; $display("FAIL ign_wrong_ack: got %h want c0000003", d); end
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL ign_oint_svc: got %b want 0", oint); end
    bus_write(3'd7, 32'h0);
    bus_read(3'd7, d);
    n_checks++; if (d !== 32'h49430001) begin n_fail++; $display("FAIL ign_id_write: got %h want 49430001", d); end
    bus_write(3'd5, 32'd3);
    bus_read(3'd4, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ign_idle_vector: got %h want 00000000", d); end
  endtask

  task automatic test_nmi;
    bus_write(3'd2, 32'h00);
    nmi = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (onmi !== 1'b0) begin n_fail++; $display("FAIL nmi_early: got %b want 0", onmi); end
    @(negedge clk);
    n_checks++; if (onmi !== 1'b1) begin n_fail++; $display("FAIL nmi_rise: got %b want 1", onmi); end
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL nmi_oint_masked: got %b want 0", oint); end
    nmi = 1'b0;
    repeat (3) @(negedge clk);
    // Fresh edge reaches NMIPEND on exactly the edge that latches the clear write.
    @(negedge clk); nmi = 1'b1;
    @(negedge clk);
    bus_write(3'd6, 32'h1);
    nmi = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (onmi !== 1'b1) begin n_fail++; $display("FAIL nmi_set_wins: got %b want 1", onmi); end
    bus_read(3'd6, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL nmi_ctl_set: got %h want 00000001", d); end
    bus_write(3'd6, 32'h1);
    repeat (2) @(negedge clk);
    n_checks++; if (onmi !== 1'b0) begin n_fail++; $display("FAIL nmi_clear: got %b want 0", onmi); end
    bus_read(3'd6, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL nmi_ctl_clear: got %h want 00000000", d); end
  endtask

  task automatic test_reset_mid;
    bus_write(3'd2, 32'hFF);
    bus_write(3'd3, 32'h0F);
    irq[6] = 1'b1; nmi = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (oint !== 1'b1) begin n_fail++; $display("FAIL rstmid_oint_pre: got %b want 1", oint); end
    n_checks++; if (onmi !== 1'b1) begin n_fail++; $display("FAIL rstmid_onmi_pre: got %b want 1", onmi); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (oint !== 1'b0) begin n_fail++; $display("FAIL rstmid_oint_async: got %b want 0", oint); end
    n_checks++; if (onmi !== 1'b0) begin n_fail++; $display("FAIL rstmid_onmi_async: got %b want 0", onmi); end
    irq = '0; nmi = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(3'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_mask: got %h want 00000000", d); end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'hFF) begin n_fail++; $display("FAIL rstmid_edge: got %h want 000000ff", d); end
    bus_read(3'd7, d);
    n_checks++; if (d !== 32'h49430001) begin n_fail++; $display("FAIL rstmid_id: got %h want 49430001", d); end
    bus_read(3'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_pending: got %h want 00000000", d); end
  endtask

  initial begin
    test_reset;
    test_edge;
    test_priority;
    test_level;
    test_ignored;
    test_nmi;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
